// File: rtl/mips_pkg.sv
// Shared opcode and hazard-controller state encodings for the pipeline control blocks.
package mips_pkg;

    typedef enum logic [3:0] {
        OpNop    = 4'b0000,
        OpImm    = 4'b1001,
        OpLoad   = 4'b1010,
        OpStore  = 4'b1011,
        OpBranch = 4'b1100
    } opcode_e;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StBrId    = 2'd1,
        StBrFlush = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: stage operand info in, stall/flush controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import mips_pkg::*;

    logic [3:0]       id_op;
    logic [2:0]       id_src1;
    logic [2:0]       id_src2;
    logic [2:0]       ex_dest;
    logic             ex_wb_en;
    logic             ex_is_load;
    logic [2:0]       mem_dest;
    logic             mem_wb_en;
    logic             branch_en_stall;
    logic             branch_taken;
    logic             if_hold;
    logic             id_hold;
    logic             ex_bubble;
    logic             if_flush;
    logic [CNT_W-1:0] stall_count;
    state_e           fsm_state;

    // master: the pipeline datapath; slave: the hazard controller
    modport master (
        output id_op, id_src1, id_src2, ex_dest, ex_wb_en, ex_is_load,
               mem_dest, mem_wb_en, branch_en_stall, branch_taken,
        input  if_hold, id_hold, ex_bubble, if_flush, stall_count, fsm_state
    );

    modport slave (
        input  id_op, id_src1, id_src2, ex_dest, ex_wb_en, ex_is_load,
               mem_dest, mem_wb_en, branch_en_stall, branch_taken,
        output if_hold, id_hold, ex_bubble, if_flush, stall_count, fsm_state
    );

endinterface

// File: rtl/hazard_match.sv
// Register-match detector: one ID source against one stage destination.
module hazard_match (
    input  logic [2:0] src_i,
    input  logic [2:0] dest_i,
    input  logic       wb_en_i,
    output logic       hit_o
);

    // Register 0 encodes "operand unused", so it can never alias a destination.
    assign hit_o = wb_en_i && (src_i != 3'd0) && (src_i == dest_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: combinational RAW detection with bubble insertion, plus branch
// sequencing (hold IF while the branch resolves in ID, flush IF/ID when taken).
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned FW_EN = 1,
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    logic ex1_hit, ex2_hit, mem1_hit, mem2_hit;
    logic load_use, data_hazard;
    logic if_hold_c, ex_bubble_c, if_flush_c;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    hazard_match u_match_ex_src1 (
        .src_i   (bus.id_src1),
        .dest_i  (bus.ex_dest),
        .wb_en_i (bus.ex_wb_en),
        .hit_o   (ex1_hit)
    );

    hazard_match u_match_ex_src2 (
        .src_i   (bus.id_src2),
        .dest_i  (bus.ex_dest),
        .wb_en_i (bus.ex_wb_en),
        .hit_o   (ex2_hit)
    );

    hazard_match u_match_mem_src1 (
        .src_i   (bus.id_src1),
        .dest_i  (bus.mem_dest),
        .wb_en_i (bus.mem_wb_en),
        .hit_o   (mem1_hit)
    );

    hazard_match u_match_mem_src2 (
        .src_i   (bus.id_src2),
        .dest_i  (bus.mem_dest),
        .wb_en_i (bus.mem_wb_en),
        .hit_o   (mem2_hit)
    );

    // With forwarding only a load result is too late; without it any pending write stalls.
    always_comb begin
        load_use    = bus.ex_is_load && (ex1_hit || ex2_hit);
        data_hazard = 1'b0;
        if (bus.id_op != OpNop) begin
            if (FW_EN != 0) begin
                data_hazard = load_use;
            end else begin
                data_hazard = ex1_hit || ex2_hit || mem1_hit || mem2_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        if_hold_c   = 1'b0;
        ex_bubble_c = 1'b0;
        if_flush_c  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.branch_en_stall && !data_hazard) begin
                    state_d = StBrId;
                end
            end
            StBrId: begin
                if_hold_c = 1'b1;
                if (!data_hazard) begin
                    state_d = bus.branch_taken ? StBrFlush : StRun;
                end
            end
            StBrFlush: begin
                if_flush_c = 1'b1;
                state_d    = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
        // Data stalls override branch sequencing; ID/EX keeps moving so the bubble enters EX.
        if (data_hazard) begin
            if_hold_c   = 1'b1;
            ex_bubble_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (if_hold_c && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Combinational controls are forced low while reset is held.
    assign bus.if_hold     = rst && if_hold_c;
    assign bus.ex_bubble   = rst && ex_bubble_c;
    assign bus.if_flush    = rst && if_flush_c;
    assign bus.id_hold     = 1'b0;
    assign bus.stall_count = stall_q;
    assign bus.fsm_state   = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter FW_EN, default 1, meaning the EX/MEM forwarding paths exist; 0 means stall on every RAW hazard.
REQ-002 SHALL have parameter CNT_W, default 16, giving the stall counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port id_op, input, 4 bits: opcode of the instruction in ID.
REQ-006 SHALL have ports id_src1 and id_src2, input, 3 bits each: ID source registers; 0 means unused.
REQ-007 SHALL have ports ex_dest, ex_wb_en and ex_is_load, inputs of 3, 1 and 1 bits: the EX-stage destination register, write-back enable and load flag.
REQ-008 SHALL have ports mem_dest and mem_wb_en, inputs of 3 and 1 bits: the MEM-stage destination register and write-back enable.
REQ-009 SHALL have port branch_en_stall, input, 1 bit: the instruction in IF has opcode 4'b1100.
REQ-010 SHALL have port branch_taken, input, 1 bit: the branch in ID resolved as taken.
REQ-011 SHALL have port if_hold, output, 1 bit: freezes PC and the IF/ID register; drives instruction_decode_en.
REQ-012 SHALL have port id_hold, output, 1 bit: freezes the ID/EX register; drives enable.
REQ-013 SHALL have port ex_bubble, output, 1 bit: forces a NOP (opcode 0) into ID/EX.
REQ-014 SHALL have port if_flush, output, 1 bit: replaces the IF/ID content with a NOP.
REQ-015 SHALL have port stall_count, output, CNT_W bits: saturating count of stall cycles.

Function
REQ-016 A register match SHALL mean src != 0, the dest equals src, and the stage's wb_en = 1.
REQ-017 A load-use hazard SHALL mean ex_is_load = 1 with a match of ex_dest on either ID source.
REQ-018 When FW_EN = 0, a data hazard SHALL mean any match on either ID source against EX or MEM; when FW_EN = 1, it SHALL mean a load-use hazard only.
REQ-019 Hazard detection SHALL be combinational, with zero-cycle latency from inputs to if_hold, id_hold and ex_bubble.
REQ-020 On a data hazard, the block SHALL assert if_hold = 1 and ex_bubble = 1 and hold id_hold = 0, so the bubble enters EX.
REQ-021 The FSM SHALL have the states RUN, BR_ID and BR_FLUSH, encoded 2'd0, 2'd1 and 2'd2.
REQ-022 In RUN, with branch_en_stall = 1 and no data hazard, the next state SHALL be BR_ID; otherwise the FSM SHALL stay in RUN.
REQ-023 In BR_ID, if_hold SHALL be 1 so no wrong-path fetch occurs.
REQ-024 In BR_ID with a data hazard, the FSM SHALL stay in BR_ID and apply REQ-020.
REQ-025 In BR_ID without a data hazard, the next state SHALL be BR_FLUSH if branch_taken = 1 and RUN otherwise.
REQ-026 In BR_FLUSH, if_flush SHALL be 1 for exactly one cycle, and the next state SHALL be RUN unconditionally.
REQ-027 In BR_FLUSH, the block SHALL ignore branch_en_stall, because the flushed slot holds no valid branch.
REQ-028 Data-hazard stalls SHALL take priority over branch sequencing.
REQ-029 Simultaneous events: a data hazard together with branch_en_stall in RUN SHALL keep the FSM in RUN.
REQ-030 stall_count SHALL increment by 1 on each cycle where if_hold = 1.
REQ-031 stall_count SHALL saturate at all-ones and never wrap.
REQ-032 Opcode 4'b0000 (NOP) in ID SHALL never produce a hazard, whatever its source fields.
REQ-033 Outputs SHALL be X-free whenever rst = 1.

Reset
REQ-034 With rst = 0, the block SHALL immediately set state = RUN, stall_count = 0, and if_hold, id_hold, ex_bubble and if_flush to 0.
REQ-035 Reset asserted mid-branch (BR_ID or BR_FLUSH) SHALL abort the sequence without producing a flush pulse.
REQ-036 Release of rst SHALL take effect on the first rising clk edge after deassertion.

Structure
REQ-037 The opcodes (NOP 4'b0000, IMM 4'b1001, LOAD 4'b1010, STORE 4'b1011, BRANCH 4'b1100) and the FSM state encodings SHALL reside in the shared package mips_pkg.
REQ-038 Match logic SHALL be one sub-module, hazard_match: combinational, taking src, dest and wb_en and producing hit; it SHALL be instantiated four times.
REQ-039 The target implementation size is 120-250 lines of RTL.

Verification
REQ-040 Load-use: EX LOAD with ex_dest = 3 and ex_wb_en = 1, ID src1 = 3 -> if_hold = 1 and ex_bubble = 1 for one cycle, stall_count = 1.
REQ-041 FW_EN = 0 MEM hazard: mem_dest = 5 with mem_wb_en = 1, id_src2 = 5 -> if_hold = 1 each cycle until mem_wb_en = 0; with FW_EN = 1 -> no stall.
REQ-042 Taken branch: branch_en_stall = 1 in RUN, then branch_taken = 1 -> states RUN, BR_ID, BR_FLUSH, RUN, with if_flush = 1 for exactly one cycle.
REQ-043 Untaken branch: the same stimulus with branch_taken = 0 -> RUN, BR_ID, RUN; if_flush never 1.
REQ-044 Branch plus load-use: in BR_ID, ex_dest = 2 load and id_src1 = 2 -> one extra BR_ID cycle with ex_bubble = 1, then normal resolution.
REQ-045 Async reset in BR_ID and saturation: rst = 0 asynchronously -> all outputs 0 and state RUN before the next edge; with CNT_W = 2, 5 stall cycles -> stall_count = 3.
